// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order writeback queue feeding the register file
// Two-source (mem, alu) accept, one drain per cycle, with youngest-match forwarding to decode.
module regfile_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     aluValid,
   input  logic [4:0]               aluRegister,
   input  logic [31:0]              aluData,
   output logic                     aluReady,
   input  logic                     memValid,
   input  logic [4:0]               memRegister,
   input  logic [31:0]              memData,
   output logic                     memReady,
   output logic [4:0]               writeRegister,
   output logic [31:0]              writeData,
   output logic                     regWrite,
   input  logic [4:0]               fwdRegister1,
   input  logic [4:0]               fwdRegister2,
   output logic                     fwdHit1,
   output logic                     fwdHit2,
   output logic [31:0]              fwdData1,
   output logic [31:0]              fwdData2,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    regMem  [DEPTH];
   logic [31:0]   dataMem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] slots;
   logic          memNeeds;
   logic          memPush;
   logic          aluPush;
   logic          pop;
   logic [1:0]    pushes;

   // Scan oldest to youngest so the last match wins; entries outside count are stale.
   function automatic logic [32:0] lookup(input logic [4:0] addr);
      logic [32:0]   r;
      logic [AW-1:0] idx;
      r = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (addr != 5'd0 && CW'(i) < count && regMem[idx] == addr)
            r = {1'b1, dataMem[idx]};
      end
      return r;
   endfunction

   always_comb begin
      pop      = (count != '0);
      slots    = CW'(DEPTH) - count + CW'(pop);
      memNeeds = memValid && (memRegister != 5'd0);
      memReady = (slots != '0);
      aluReady = ({1'b0, slots} >= ((CW+1)'(1) + (CW+1)'(memNeeds)));
      memPush  = memValid && memReady && (memRegister != 5'd0);
      aluPush  = aluValid && aluReady && (aluRegister != 5'd0);
      pushes   = {1'b0, memPush} + {1'b0, aluPush};
   end

   always_comb begin
      regWrite      = pop;
      writeRegister = pop ? regMem[head]  : 5'd0;
      writeData     = pop ? dataMem[head] : 32'd0;
      {fwdHit1, fwdData1} = lookup(fwdRegister1);
      {fwdHit2, fwdData2} = lookup(fwdRegister2);
   end

   // Memory result belongs to the older instruction, so it takes the first free position.
   always_ff @(posedge clk) begin
      if (memPush) begin
         regMem[tail]  <= memRegister;
         dataMem[tail] <= memData;
      end
      if (aluPush) begin
         regMem[tail + AW'(memPush)]  <= aluRegister;
         dataMem[tail + AW'(memPush)] <= aluData;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop);
         tail  <= tail + AW'(pushes);
         count <= count + CW'(pushes) - CW'(pop);
      end
   end
endmodule
